// File: rtl/fir_coeff_sequencer_pkg.sv
// Shared definitions for the FIR coefficient sequencer: FSM states, size
// defaults, window-type codes and the filter-order clamp.
package fir_pkg;

  localparam int unsigned N_MAX_DEF = 256;
  localparam int unsigned IDX_W_DEF = 16;

  localparam logic [3:0] WIN_RECT     = 4'd0;
  localparam logic [3:0] WIN_HANN     = 4'd1;
  localparam logic [3:0] WIN_HAMMING  = 4'd2;
  localparam logic [3:0] WIN_BLACKMAN = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_WAIT_FALL = 3'd3,
    ST_WRITE     = 3'd4,
    ST_SWAP_PEND = 3'd5,
    ST_RUN       = 3'd6
  } state_t;

  function automatic int unsigned clamp_n(input int unsigned n, input int unsigned n_max);
    return (n > n_max) ? n_max : n;
  endfunction

endpackage

// File: rtl/fir_coeff_sequencer_if.sv
// Generator handshake and coefficient-bank write bus between the sequencer
// (master) and the window generator / coefficient RAM (slave).
interface fir_coeff_sequencer_if #(
  parameter int unsigned IDX_W = 16
);
  logic                    win_en;
  logic [IDX_W-1:0]        win_idx;
  logic [3:0]              win_type;
  logic [7:0]              win_lgn;
  logic [15:0]             win_pi_phase;
  logic                    win_busy;
  logic signed [15:0]      win_data;
  logic                    coef_we;
  logic [IDX_W-1:0]        coef_addr;
  logic signed [15:0]      coef_wdata;
  logic                    coef_wbank;

  modport master (
    output win_en, win_idx, win_type, win_lgn, win_pi_phase,
    input  win_busy, win_data,
    output coef_we, coef_addr, coef_wdata, coef_wbank
  );

  modport slave (
    input  win_en, win_idx, win_type, win_lgn, win_pi_phase,
    output win_busy, win_data,
    input  coef_we, coef_addr, coef_wdata, coef_wbank
  );
endinterface

// File: rtl/fir_coeff_sequencer_warmup_cnt.sv
// Counts sample strobes after a bank swap, saturating at the tap count, and
// flags the filter output as settled once the delay line is full.
module fir_warmup_cnt
  import fir_pkg::*;
#(
  parameter int unsigned W = IDX_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         valid
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign valid = (cnt == limit);

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Loads windowed-FIR coefficients tap by tap into the shadow bank, then swaps
// banks on a sample strobe. Optional watchdog: define FIR_SEQ_TIMEOUT_EN.
module fir_coeff_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned N_MAX = N_MAX_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
`ifdef FIR_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          cfg_win_type,
  input  logic [IDX_W-1:0]    cfg_n,
  input  logic [7:0]          cfg_lgn,
  input  logic [15:0]         cfg_pi_phase,
  input  logic                sample_stb,
  fir_coeff_sequencer_if.master bus,
  output logic                bank_sel,
  output logic                load_busy,
  output logic                filt_valid,
  output logic                seq_err
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   n_r;
  logic [IDX_W-1:0]   n_live;
  logic [3:0]         win_type_r;
  logic signed [15:0] data_r;
  logic               rise_seen;
  logic               cfg_chg;
  logic               start_ok;
  logic               wu_clr;
  logic [IDX_W:0]     wu_limit;

  assign n_live  = IDX_W'(clamp_n(32'(cfg_n), N_MAX));
  assign cfg_chg = (cfg_win_type != win_type_r) || (n_live != n_r);

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             armed;
  logic             waiting;
  logic             tmo_hit;

  assign waiting  = ((state == ST_WAIT_RISE) && !(bus.win_busy || rise_seen)) ||
                    ((state == ST_WAIT_FALL) && bus.win_busy);
  assign tmo_hit  = waiting && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign start_ok = armed;

  // A timeout parks the block in IDLE until en has been cycled low.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      armed   <= 1'b1;
      seq_err <= 1'b0;
    end else begin
      tmo_cnt <= waiting ? tmo_cnt + 1'b1 : '0;
      if (!en) begin
        armed <= 1'b1;
      end else if (!cfg_chg && tmo_hit) begin
        armed   <= 1'b0;
        seq_err <= 1'b1;
      end
    end
  end
`else
  assign start_ok = 1'b1;
  assign seq_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      n_r        <= '0;
      win_type_r <= '0;
      data_r     <= '0;
      rise_seen  <= 1'b0;
      bank_sel   <= 1'b0;
    end else if (!en) begin
      state <= ST_IDLE;
    end else if ((state != ST_IDLE) && cfg_chg) begin
      // Restart discards the shadow contents; the active bank is never touched.
      state      <= ST_ISSUE;
      idx        <= '0;
      n_r        <= n_live;
      win_type_r <= cfg_win_type;
`ifdef FIR_SEQ_TIMEOUT_EN
    end else if (tmo_hit) begin
      state <= ST_IDLE;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state      <= ST_ISSUE;
            idx        <= '0;
            n_r        <= n_live;
            win_type_r <= cfg_win_type;
          end
        end
        ST_ISSUE: begin
          // Busy may already rise alongside win_en; remember it for WAIT_RISE.
          rise_seen <= bus.win_busy;
          state     <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (bus.win_busy || rise_seen) begin
            state <= ST_WAIT_FALL;
          end
        end
        ST_WAIT_FALL: begin
          if (!bus.win_busy) begin
            data_r <= bus.win_data;
            state  <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (idx == n_r) begin
            state <= ST_SWAP_PEND;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_ISSUE;
          end
        end
        ST_SWAP_PEND: begin
          if (sample_stb) begin
            bank_sel <= ~bank_sel;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Counter is held cleared outside RUN and on any edge that leaves RUN.
  assign wu_clr   = !en || cfg_chg || (state != ST_RUN);
  assign wu_limit = {1'b0, n_r} + 1'b1;

  fir_warmup_cnt #(
    .W(IDX_W + 1)
  ) u_warmup (
    .clk  (clk),
    .rst  (rst),
    .clr  (wu_clr),
    .inc  (sample_stb),
    .limit(wu_limit),
    .valid(filt_valid)
  );

  assign bus.win_en       = (state == ST_ISSUE);
  assign bus.win_idx      = idx;
  assign bus.win_type     = win_type_r;
  assign bus.win_lgn      = cfg_lgn;
  assign bus.win_pi_phase = cfg_pi_phase;
  assign bus.coef_we      = (state == ST_WRITE);
  assign bus.coef_addr    = idx;
  assign bus.coef_wdata   = data_r;
  assign bus.coef_wbank   = ~bank_sel;

  assign load_busy = (state != ST_IDLE) && (state != ST_RUN);

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Self-checking bench for fir_coeff_sequencer: randomized generator latency and
// configurations against a tap-list / strobe-count reference model.
module tb_fir_coeff_sequencer;
  import fir_pkg::*;

  localparam int unsigned IDX_W = 16;
  localparam int unsigned N_MAX = 256;

  typedef struct packed {
    logic        bank;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst, en, sample_stb;
  logic [3:0]  cfg_win_type;
  logic [15:0] cfg_n;
  logic [7:0]  cfg_lgn;
  logic [15:0] cfg_pi_phase;
  logic bank_sel, load_busy, filt_valid, seq_err;

  int vecs = 0;
  int errs = 0;
  logic exp_bank;
  logic [15:0] salt;
  wr_t wr_q[$];

  always #5 clk = ~clk;

  fir_coeff_sequencer_if #(.IDX_W(IDX_W)) bus ();

  fir_coeff_sequencer #(.N_MAX(N_MAX), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_win_type(cfg_win_type), .cfg_n(cfg_n), .cfg_lgn(cfg_lgn),
    .cfg_pi_phase(cfg_pi_phase), .sample_stb(sample_stb),
    .bus(bus),
    .bank_sel(bank_sel), .load_busy(load_busy), .filt_valid(filt_valid),
    .seq_err(seq_err)
  );

  function automatic logic [15:0] gen_coef(input logic [3:0] t, input logic [15:0] i);
    return {t, i[11:0]} ^ salt;
  endfunction

  function automatic wr_t exp_wr(input logic bank, input int a, input logic [3:0] t);
    wr_t w;
    w.bank = bank;
    w.addr = 16'(a);
    w.data = gen_coef(t, 16'(a));
    return w;
  endfunction

  // Window generator model: restarts on every win_en, busy for 1..4 cycles.
  logic        gen_busy;
  logic [15:0] gen_data;
  int          gen_left;
  always @(posedge clk) begin
    if (rst) begin
      gen_busy <= 1'b0;
      gen_left <= 0;
      gen_data <= '0;
    end else if (bus.win_en) begin
      gen_busy <= 1'b1;
      gen_left <= $urandom_range(1, 4);
      gen_data <= gen_coef(bus.win_type, bus.win_idx);
    end else if (gen_left > 1) begin
      gen_left <= gen_left - 1;
    end else begin
      gen_left <= 0;
      gen_busy <= 1'b0;
    end
  end
  assign bus.win_busy = gen_busy;
  assign bus.win_data = gen_data;

  always @(negedge clk) begin
    if (bus.coef_we) wr_q.push_back('{bank: bus.coef_wbank, addr: bus.coef_addr, data: bus.coef_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_stb();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic wait_writes(input int cnt, input bit noise, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (wr_q.size() >= cnt) begin
        ok = 1'b1;
        break;
      end
      sample_stb = noise && ($urandom_range(0, 3) == 0);
      tick();
    end
    sample_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sample_stb = 1'b0;
    cfg_win_type = WIN_HANN; cfg_n = 16'd4; cfg_lgn = 8'd3; cfg_pi_phase = 16'h1234;
    repeat (3) tick();
    vecs++; if (bank_sel !== 1'b0) begin errs++; $display("FAIL reset_bank_sel: got %b want 0", bank_sel); end
    vecs++; if (load_busy !== 1'b0) begin errs++; $display("FAIL reset_load_busy: got %b want 0", load_busy); end
    vecs++; if (filt_valid !== 1'b0) begin errs++; $display("FAIL reset_filt_valid: got %b want 0", filt_valid); end
    vecs++; if (bus.coef_we !== 1'b0) begin errs++; $display("FAIL reset_coef_we: got %b want 0", bus.coef_we); end
    vecs++; if (bus.win_en !== 1'b0) begin errs++; $display("FAIL reset_win_en: got %b want 0", bus.win_en); end
    vecs++; if (seq_err !== 1'b0) begin errs++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    rst = 1'b0;
    repeat (2) tick();
    vecs++; if (load_busy !== 1'b0) begin errs++; $display("FAIL idle_no_en_busy: got %b want 0", load_busy); end
    exp_bank = 1'b0;
  endtask

  task automatic test_basic_load();
    bit ok;
    wr_q.delete();
    en = 1'b1;
    wait_writes(5, 1'b0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL basic_timeout: got %0d writes want 5", wr_q.size()); end
    repeat (8) tick();
    vecs++; if (wr_q.size() != 5) begin errs++; $display("FAIL basic_wr_count: got %0d want 5", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_wr(~exp_bank, i, WIN_HANN)) begin
        errs++; $display("FAIL basic_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr(~exp_bank, i, WIN_HANN));
      end
    end
    vecs++; if (load_busy !== 1'b1) begin errs++; $display("FAIL basic_swap_pend_busy: got %b want 1", load_busy); end
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL basic_bank_pre: got %b want %b", bank_sel, exp_bank); end
    pulse_stb();
    exp_bank = ~exp_bank;
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL basic_bank_swap: got %b want %b", bank_sel, exp_bank); end
    vecs++; if (load_busy !== 1'b0) begin errs++; $display("FAIL basic_run_busy: got %b want 0", load_busy); end
    for (int k = 1; k <= 7; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      pulse_stb();
      vecs++;
      if (filt_valid !== (k >= 5)) begin errs++; $display("FAIL basic_warmup[%0d]: got %b want %b", k, filt_valid, k >= 5); end
    end
  endtask

  task automatic test_cfg_change();
    bit ok, saw_valid, bank_moved;
    wr_q.delete();
    cfg_win_type = WIN_HAMMING;
    tick();
    vecs++; if (filt_valid !== 1'b0) begin errs++; $display("FAIL chg_valid_drop: got %b want 0", filt_valid); end
    wait_writes(2, 1'b0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL chg_first_timeout: got %0d writes want 2", wr_q.size()); end
    cfg_n = 16'd8;
    wr_q.delete();
    saw_valid = 1'b0; bank_moved = 1'b0;
    for (int c = 0; c < 6000 && wr_q.size() < 9; c++) begin
      tick();
      if (filt_valid !== 1'b0) saw_valid = 1'b1;
      if (bank_sel !== exp_bank) bank_moved = 1'b1;
    end
    repeat (5) tick();
    vecs++; if (wr_q.size() != 9) begin errs++; $display("FAIL chg_wr_count: got %0d want 9", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_wr(~exp_bank, i, WIN_HAMMING)) begin
        errs++; $display("FAIL chg_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr(~exp_bank, i, WIN_HAMMING));
      end
    end
    vecs++; if (saw_valid) begin errs++; $display("FAIL chg_valid_during_load: got 1 want 0"); end
    vecs++; if (bank_moved) begin errs++; $display("FAIL chg_bank_during_load: got moved want held %b", exp_bank); end
    pulse_stb();
    exp_bank = ~exp_bank;
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL chg_bank_swap: got %b want %b", bank_sel, exp_bank); end
  endtask

  task automatic test_clamp();
    bit ok;
    wr_q.delete();
    cfg_win_type = WIN_BLACKMAN;
    cfg_n = 16'd300;
    wait_writes(257, 1'b0, ok);
    repeat (6) tick();
    vecs++; if (!ok || wr_q.size() != 257) begin errs++; $display("FAIL clamp_wr_count: got %0d want 257", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_wr(~exp_bank, i, WIN_BLACKMAN)) begin
        errs++; $display("FAIL clamp_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr(~exp_bank, i, WIN_BLACKMAN));
      end
    end
    vecs++;
    if (wr_q.size() == 0 || wr_q[wr_q.size()-1].addr !== 16'd256) begin
      errs++; $display("FAIL clamp_last_addr: got %0d want 256", (wr_q.size() == 0) ? 0 : wr_q[wr_q.size()-1].addr);
    end
    pulse_stb();
    exp_bank = ~exp_bank;
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL clamp_bank_swap: got %b want %b", bank_sel, exp_bank); end
  endtask

  task automatic test_swap_collision();
    bit ok;
    wr_q.delete();
    cfg_win_type = WIN_RECT;
    cfg_n = 16'd3;
    wait_writes(4, 1'b0, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL coll_first_timeout: got %0d writes want 4", wr_q.size()); end
    cfg_n = 16'd6;
    sample_stb = 1'b1;
    wr_q.delete();
    tick();
    sample_stb = 1'b0;
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL coll_no_swap: got %b want %b", bank_sel, exp_bank); end
    vecs++; if (load_busy !== 1'b1) begin errs++; $display("FAIL coll_busy: got %b want 1", load_busy); end
    wait_writes(7, 1'b0, ok);
    repeat (4) tick();
    vecs++; if (!ok || wr_q.size() != 7) begin errs++; $display("FAIL coll_wr_count: got %0d want 7", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_wr(~exp_bank, i, WIN_RECT)) begin
        errs++; $display("FAIL coll_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr(~exp_bank, i, WIN_RECT));
      end
    end
    pulse_stb();
    exp_bank = ~exp_bank;
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL coll_bank_swap: got %b want %b", bank_sel, exp_bank); end
  endtask

  task automatic test_en_drop();
    bit ok;
    int k;
    for (int s = 0; s < 7; s++) pulse_stb();
    vecs++; if (filt_valid !== 1'b1) begin errs++; $display("FAIL endrop_pre_valid: got %b want 1", filt_valid); end
    en = 1'b0;
    tick();
    vecs++; if (filt_valid !== 1'b0) begin errs++; $display("FAIL endrop_run_valid: got %b want 0", filt_valid); end
    en = 1'b1;
    k = $urandom_range(1, 4);
    wr_q.delete();
    cfg_win_type = 4'd5;
    wait_writes(k, 1'b0, ok);
    en = 1'b0;
    tick();
    vecs++; if (load_busy !== 1'b0) begin errs++; $display("FAIL endrop_idle: got busy %b want 0", load_busy); end
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL endrop_bank_held: got %b want %b", bank_sel, exp_bank); end
    repeat (4) tick();
    vecs++; if (wr_q.size() != k) begin errs++; $display("FAIL endrop_no_writes: got %0d want %0d", wr_q.size(), k); end
    en = 1'b1;
    wr_q.delete();
    wait_writes(7, 1'b0, ok);
    repeat (4) tick();
    vecs++; if (!ok || wr_q.size() != 7) begin errs++; $display("FAIL endrop_wr_count: got %0d want 7", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      vecs++;
      if (wr_q[i] !== exp_wr(~exp_bank, i, 4'd5)) begin
        errs++; $display("FAIL endrop_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr(~exp_bank, i, 4'd5));
      end
    end
    pulse_stb();
    exp_bank = ~exp_bank;
    vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL endrop_bank_swap: got %b want %b", bank_sel, exp_bank); end
  endtask

  task automatic test_random_loads();
    bit ok;
    int n;
    logic [3:0] t;
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? 0 : $urandom_range(1, 12);
      t = 4'($urandom_range(0, 15));
      if (t == cfg_win_type && 16'(n) == cfg_n) t = t ^ 4'd1;
      wr_q.delete();
      cfg_win_type = t;
      cfg_n = 16'(n);
      cfg_lgn = 8'($urandom);
      cfg_pi_phase = 16'($urandom);
      wait_writes(n + 1, 1'b1, ok);
      repeat (3) tick();
      vecs++; if (!ok || wr_q.size() != n + 1) begin errs++; $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, wr_q.size(), n + 1); end
      for (int i = 0; i < wr_q.size(); i++) begin
        vecs++;
        if (wr_q[i] !== exp_wr(~exp_bank, i, t)) begin
          errs++; $display("FAIL rnd%0d_wr[%0d]: got %h want %h", it, i, wr_q[i], exp_wr(~exp_bank, i, t));
        end
      end
      vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL rnd%0d_bank_held: got %b want %b", it, bank_sel, exp_bank); end
      vecs++;
      if (bus.win_type !== t || bus.win_lgn !== cfg_lgn || bus.win_pi_phase !== cfg_pi_phase) begin
        errs++; $display("FAIL rnd%0d_passthru: got %h/%h/%h want %h/%h/%h", it, bus.win_type, bus.win_lgn, bus.win_pi_phase, t, cfg_lgn, cfg_pi_phase);
      end
      pulse_stb();
      exp_bank = ~exp_bank;
      vecs++; if (bank_sel !== exp_bank) begin errs++; $display("FAIL rnd%0d_bank_swap: got %b want %b", it, bank_sel, exp_bank); end
      for (int s = 1; s <= n + 3; s++) begin
        repeat ($urandom_range(0, 2)) tick();
        pulse_stb();
        vecs++;
        if (filt_valid !== (s >= n + 1)) begin errs++; $display("FAIL rnd%0d_warmup[%0d]: got %b want %b", it, s, filt_valid, s >= n + 1); end
      end
      vecs++; if (seq_err !== 1'b0) begin errs++; $display("FAIL rnd%0d_seq_err: got %b want 0", it, seq_err); end
    end
  endtask

  initial begin
    salt = 16'($urandom);
    test_reset();
    test_basic_load();
    test_cfg_change();
    test_clamp();
    test_swap_collision();
    test_en_drop();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
